// File: rtl/display_pkg.sv
// Shared types and default 640x480@60 timing for the display timing controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/display_timing_ctrl_if.sv
// Control/strobe and timing-output bundle between the system FSM, the divider and the display stage.
interface display_timing_ctrl_if #(
  parameter int CNT_W = display_pkg::DEF_CNT_W
);
  import display_pkg::*;

  // start/stop/pixel_tick are one-clk strobes with no ready: each high cycle is
  // one request, taken or ignored in that same cycle depending on state.
  logic             start;
  logic             stop;
  logic             pixel_tick;
  logic             div_enable;
  logic             hsync;
  logic             vsync;
  logic             active_video;
  logic [CNT_W-1:0] x_pos;
  logic [CNT_W-1:0] y_pos;
  logic             frame_start;
  logic             busy;
  state_t           state;

  modport master (
    output start, stop, pixel_tick,
    input  div_enable, hsync, vsync, active_video, x_pos, y_pos, frame_start, busy, state
  );

  modport slave (
    input  start, stop, pixel_tick,
    output div_enable, hsync, vsync, active_video, x_pos, y_pos, frame_start, busy, state
  );

endinterface

// File: rtl/axis_timing.sv
// One scan axis: wrapping position counter plus sync/active decode for that axis.
module axis_timing #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_n,
  output logic         active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  assign wrap   = advance && (count == LAST);
  assign sync_n = !((count >= SYNC_LO) && (count < SYNC_HI));
  assign active = (count < ACT_END);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/display_timing_ctrl.sv
// Scan sequencer: gates the pixel divider, steps h/v counters on pixel strobes, decodes sync/blank.
module display_timing_ctrl
  import display_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           n_rst,
  display_timing_ctrl_if.slave bus
);

  state_t           state;
  logic             div_enable_q;
  logic             frame_start_q;
  logic             busy_q;
  logic             scanning;
  logic             clear;
  logic             h_adv;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_n;
  logic             v_sync_n;
  logic             h_active;
  logic             v_active;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;

  assign scanning = (state == RUN) || (state == DRAIN);
  assign clear    = !scanning;
  assign h_adv    = scanning && bus.pixel_tick;

  axis_timing #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h_axis (
    .clk(clk), .n_rst(n_rst), .advance(h_adv), .clear(clear),
    .count(h_count), .wrap(h_wrap), .sync_n(h_sync_n), .active(h_active)
  );

  // Vertical axis steps once per completed line, so its wrap marks the frame wrap.
  axis_timing #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v_axis (
    .clk(clk), .n_rst(n_rst), .advance(h_wrap), .clear(clear),
    .count(v_count), .wrap(v_wrap), .sync_n(v_sync_n), .active(v_active)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      div_enable_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state        <= ARM;
            div_enable_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ARM: begin
          if (bus.stop) begin
            state        <= IDLE;
            div_enable_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (bus.pixel_tick) begin
            state         <= RUN;
            frame_start_q <= 1'b1;
          end
        end
        RUN: begin
          if (v_wrap) frame_start_q <= 1'b1;
          if (bus.stop) state <= DRAIN;
        end
        DRAIN: begin
          // The stop is already latched; the frame finishes before the divider is released.
          if (v_wrap) begin
            state        <= IDLE;
            div_enable_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          div_enable_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_enable   = div_enable_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.busy         = busy_q;
  assign bus.state        = state;
  assign bus.x_pos        = h_count;
  assign bus.y_pos        = v_count;
  assign bus.active_video = scanning && h_active && v_active;
  assign bus.hsync        = scanning ? h_sync_n : 1'b1;
  assign bus.vsync        = scanning ? v_sync_n : 1'b1;

endmodule

// File: doc/display_timing_ctrl.md
Name: display_timing_ctrl

Overview:
Sequencing controller for the pixel clock divider. Starts and stops the divider through its enable input and consumes its one-clk pixel strobe. Maintains horizontal and vertical pixel counters and decodes them into sync, blanking, coordinate and frame-start signals for the downstream pixel/render logic. Sits between the system control FSM (start/stop) and the display output stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-clk request to begin scanning; honoured only in IDLE
stop  in  1  one-clk request to stop at end of current frame
pixel_tick  in  1  one-clk strobe from clock divider; one pixel period per strobe
div_enable  out  1  enable to clock divider
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
active_video  out  1  high while (h,v) inside visible area
x_pos  out  CNT_W  current horizontal count
y_pos  out  CNT_W  current vertical count
frame_start  out  1  one-clk pulse at start of each frame
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, h=v=0, div_enable=0, hsync=vsync=1, active_video=0, frame_start=0, busy=0.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE: div_enable=0; counters held 0; pixel_tick ignored. start & !stop -> ARM. start and stop in same cycle: stop wins, stay IDLE.
- ARM: div_enable=1; counters held (0,0). First pixel_tick -> RUN, counters not advanced. stop in ARM (before/with tick) -> IDLE.
- RUN: div_enable=1. Each pixel_tick: h increments; at h=H_TOTAL-1, h->0 and v increments; at v=V_TOTAL-1 with h wrap, v->0. stop -> DRAIN (latched; later start ignored).
- DRAIN: as RUN, but on the tick that wraps (H_TOTAL-1,V_TOTAL-1)->(0,0): -> IDLE, div_enable deasserts next cycle, counters remain 0.
- pixel_tick coincident with state transition out of RUN/DRAIN still advances counters that cycle.
- Decode (combinational from registered counters, forced to idle values outside RUN/DRAIN):
  active_video = h<H_ACTIVE && v<V_ACTIVE.
  hsync=0 when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  vsync=0 when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines).
- x_pos/y_pos = h/v in every state.
- frame_start: registered; high exactly one clk after ARM->RUN transition and one clk after every (H_TOTAL-1,V_TOTAL-1)->(0,0) wrap that stays in RUN. Never asserted for the DRAIN->IDLE wrap.
- busy = (state != IDLE).
- start in ARM/RUN/DRAIN: ignored. stop in IDLE: ignored.
- Reset mid-frame: immediate return to reset values; divider disabled asynchronously.

Decomposition:
- Package display_pkg: state enum (IDLE, ARM, RUN, DRAIN), default 640x480 timing constants, CNT_W default.
- Sub-module axis_timing (parameters ACTIVE/FP/SYNC/BP/W): counter with advance and clear inputs, outputs count, wrap (at TOTAL-1 & advance), sync_n, active. Instantiated twice; vertical advance = horizontal wrap.

Test Plan:
(Small params: H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6; 48 ticks/frame; tick every 4 clk.)
- Reset then start, first tick -> div_enable=1 in cycle after start; frame_start high one clk after first tick; x=y=0.
- Run one line -> active_video high at x=0..3, hsync low at x=5,6, x wraps 7->0 with y 0->1.
- Run full frame -> vsync low for all of y=4; frame_start pulses after 48th tick; y wraps 5->0.
- stop at x=3,y=2 -> scanning continues to (7,5); at wrap state IDLE, div_enable=0, busy=0, no frame_start; further ticks do not move counters.
- start and stop same cycle in IDLE -> stays IDLE; stop in ARM before first tick -> IDLE, no frame_start.
- n_rst asserted at x=5,y=4 -> hsync=vsync=1, x=y=0, div_enable=0 immediately.
